// File: rtl/timer_intr_gen.sv
// Machine timer: 64-bit mtime with prescaler, 64-bit mtimecmp, CTRL/STATUS; raises t_intr.
// Latency: reads are combinational (same cycle); t_intr follows the compare condition by 1 cycle.
// Backpressure: none; every access completes in one cycle, writes land on the next clk edge.
//
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   addr/wdata       byte address and store data from the MEMORY stage
//   wr_en/rd_en      store/load strobes, only acted on when hit=1
//   hit              combinational address-window decode
//   rdata            combinational read data, 0 unless rd_en && hit
//   t_intr           registered, level-sensitive timer-interrupt request
`timescale 1ns/1ps
module timer_intr_gen #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int          PRESC_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        wr_en,
    input  logic        rd_en,
    output logic        hit,
    output logic [31:0] rdata,
    output logic        t_intr
);

    localparam logic [2:0] IDX_MTIME_LO = 3'd0;
    localparam logic [2:0] IDX_MTIME_HI = 3'd1;
    localparam logic [2:0] IDX_CMP_LO   = 3'd2;
    localparam logic [2:0] IDX_CMP_HI   = 3'd3;
    localparam logic [2:0] IDX_CTRL     = 3'd4;
    localparam logic [2:0] IDX_STATUS   = 3'd5;

    logic [63:0]        mtime;
    logic [63:0]        mtimecmp;
    logic               en;
    logic               ie;
    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] presc_cnt;
    logic               pend;
    logic               wrap;

    logic [2:0]  idx;
    logic        wr_hit;
    logic        wr_mtime_lo;
    logic        wr_mtime_hi;
    logic        wr_cmp_lo;
    logic        wr_cmp_hi;
    logic        wr_ctrl;
    logic        wr_status;
    logic        tick;
    logic [32:0] lo_sum;
    logic        cmp_ge;
    logic        unused_addr_bits;

    assign hit    = (addr[31:5] == BASE_ADDR[31:5]);
    assign idx    = addr[4:2];
    assign wr_hit = wr_en && hit;

    assign wr_mtime_lo = wr_hit && (idx == IDX_MTIME_LO);
    assign wr_mtime_hi = wr_hit && (idx == IDX_MTIME_HI);
    assign wr_cmp_lo   = wr_hit && (idx == IDX_CMP_LO);
    assign wr_cmp_hi   = wr_hit && (idx == IDX_CMP_HI);
    assign wr_ctrl     = wr_hit && (idx == IDX_CTRL);
    assign wr_status   = wr_hit && (idx == IDX_STATUS);

    // Sub-word access is not supported, so the byte offset is ignored.
    assign unused_addr_bits = ^addr[1:0];

    assign tick   = en && (presc_cnt == presc);
    assign lo_sum = {1'b0, mtime[31:0]} + 33'd1;
    assign cmp_ge = (mtime >= mtimecmp);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtime     <= '0;
            mtimecmp  <= '1;
            en        <= 1'b0;
            ie        <= 1'b0;
            presc     <= '0;
            presc_cnt <= '0;
            pend      <= 1'b0;
            wrap      <= 1'b0;
            t_intr    <= 1'b0;
        end else begin
            // Software writes to a half win over a coincident tick for that half.
            if (wr_mtime_lo) begin
                mtime[31:0] <= wdata;
            end else if (tick) begin
                mtime[31:0] <= lo_sum[31:0];
            end

            // A carry only propagates when LO actually incremented and HI is not being written.
            if (wr_mtime_hi) begin
                mtime[63:32] <= wdata;
            end else if (tick && !wr_mtime_lo && lo_sum[32]) begin
                mtime[63:32] <= mtime[63:32] + 32'd1;
            end

            if (wr_cmp_lo) begin
                mtimecmp[31:0] <= wdata;
            end
            if (wr_cmp_hi) begin
                mtimecmp[63:32] <= wdata;
            end

            if (wr_ctrl) begin
                en        <= wdata[0];
                ie        <= wdata[1];
                presc     <= wdata[8 +: PRESC_W];
                presc_cnt <= '0;
            end else if (en) begin
                presc_cnt <= tick ? '0 : presc_cnt + PRESC_W'(1);
            end

            // WRAP records a genuine 64-bit rollover; setting beats a same-cycle W1C.
            if (tick && (&mtime) && !wr_mtime_lo && !wr_mtime_hi) begin
                wrap <= 1'b1;
            end else if (wr_status && wdata[1]) begin
                wrap <= 1'b0;
            end

            pend   <= cmp_ge;
            t_intr <= cmp_ge && ie;
        end
    end

    always_comb begin
        rdata = '0;
        if (rd_en && hit) begin
            case (idx)
                IDX_MTIME_LO: rdata = mtime[31:0];
                IDX_MTIME_HI: rdata = mtime[63:32];
                IDX_CMP_LO:   rdata = mtimecmp[31:0];
                IDX_CMP_HI:   rdata = mtimecmp[63:32];
                IDX_CTRL: begin
                    rdata[0]            = en;
                    rdata[1]            = ie;
                    rdata[8 +: PRESC_W] = presc;
                end
                IDX_STATUS: begin
                    rdata[0] = pend;
                    rdata[1] = wrap;
                end
                default: rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_intr_gen.sv
// Testbench for timer_intr_gen: table of register vectors plus directed multi-cycle sequences.
// Inputs are driven just after the falling edge and outputs sampled 1ns later.
// Every test step occupies exactly one rising edge of clk.
`timescale 1ns/1ps
module tb_timer_intr_gen;

    localparam logic [31:0] BASE    = 32'h0000_1000;
    localparam logic [31:0] A_LO    = BASE + 32'h00;
    localparam logic [31:0] A_HI    = BASE + 32'h04;
    localparam logic [31:0] A_CLO   = BASE + 32'h08;
    localparam logic [31:0] A_CHI   = BASE + 32'h0C;
    localparam logic [31:0] A_CTRL  = BASE + 32'h10;
    localparam logic [31:0] A_STAT  = BASE + 32'h14;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic        hit;
    logic [31:0] rdata;
    logic        t_intr;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        w;
        logic        r;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rdata;
        logic        exp_hit;
        logic        exp_t;
    } vec_t;

    vec_t tbl[$];

    timer_intr_gen #(.BASE_ADDR(BASE), .PRESC_W(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .addr   (addr),
        .wdata  (wdata),
        .wr_en  (wr_en),
        .rd_en  (rd_en),
        .hit    (hit),
        .rdata  (rdata),
        .t_intr (t_intr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        wr_en = w;
        rd_en = r;
        addr  = a;
        wdata = d;
        #1;
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
        drive(1'b1, 1'b0, a, d);
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        drive(1'b0, 1'b1, a, 32'h0);
        check(name, rdata, exp);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, BASE, 32'h0);
    endtask

    task automatic tchk(input string name, input logic exp);
        drive(1'b0, 1'b0, BASE, 32'h0);
        check(name, 32'(t_intr), 32'(exp));
    endtask

    task automatic add(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] er, input logic eh);
        vec_t v;
        v.w = w; v.r = r; v.a = a; v.d = d;
        v.exp_rdata = er; v.exp_hit = eh; v.exp_t = 1'b0;
        tbl.push_back(v);
    endtask

    initial begin
        // Reset defaults, window decode, byte-offset, reserved and read-only behaviour.
        add(0, 1, A_LO,          32'h0,         32'h0000_0000, 1);
        add(0, 1, A_HI,          32'h0,         32'h0000_0000, 1);
        add(0, 1, A_CLO,         32'h0,         32'hFFFF_FFFF, 1);
        add(0, 1, A_CHI,         32'h0,         32'hFFFF_FFFF, 1);
        add(0, 1, A_CTRL,        32'h0,         32'h0000_0000, 1);
        add(0, 1, A_STAT,        32'h0,         32'h0000_0000, 1);
        add(0, 1, BASE + 32'h18, 32'h0,         32'h0000_0000, 1);
        add(0, 1, BASE + 32'h1C, 32'h0,         32'h0000_0000, 1);
        add(0, 0, A_CLO,         32'h0,         32'h0000_0000, 1);
        add(1, 0, 32'h0000_2000, 32'h0000_1234, 32'h0000_0000, 0);
        add(0, 1, 32'h0000_2000, 32'h0,         32'h0000_0000, 0);
        add(0, 1, A_LO,          32'h0,         32'h0000_0000, 1);
        add(0, 1, 32'h0000_0FFC, 32'h0,         32'h0000_0000, 0);
        add(1, 0, A_LO,          32'h0000_A5A5, 32'h0000_0000, 1);
        add(0, 1, BASE + 32'h03, 32'h0,         32'h0000_A5A5, 1);
        add(1, 0, BASE + 32'h18, 32'hFFFF_FFFF, 32'h0000_0000, 1);
        add(0, 1, BASE + 32'h18, 32'h0,         32'h0000_0000, 1);
        add(1, 0, A_STAT,        32'h0000_0003, 32'h0000_0000, 1);
        add(0, 1, A_STAT,        32'h0,         32'h0000_0000, 1);
        add(1, 0, A_CTRL,        32'hFFFF_FFFF, 32'h0000_0000, 1);
        add(0, 1, A_CTRL,        32'h0,         32'h0000_FF03, 1);
        add(1, 1, A_CTRL,        32'h0000_0000, 32'h0000_FF03, 1);
        add(0, 1, A_CTRL,        32'h0,         32'h0000_0000, 1);

        // Outputs while reset is held.
        #2;
        check("reset t_intr", 32'(t_intr), 32'h0);
        check("reset rdata idle", rdata, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d);
            check($sformatf("tbl%0d rdata", i), rdata, tbl[i].exp_rdata);
            check($sformatf("tbl%0d hit", i), 32'(hit), 32'(tbl[i].exp_hit));
            check($sformatf("tbl%0d t_intr", i), 32'(t_intr), 32'(tbl[i].exp_t));
        end

        // Prescaler 3: one tick every 4 edges, first on the 4th edge after the CTRL write.
        wr_reg(A_LO, 32'h0);
        wr_reg(A_CTRL, 32'h0000_0301);
        idle(40);
        rd_chk("presc 40 cycles", A_LO, 32'd10);
        idle(2);
        rd_chk("presc pre-tick", A_LO, 32'd10);
        rd_chk("presc tick", A_LO, 32'd11);
        wr_reg(A_CTRL, 32'h0);
        rd_chk("presc stopped", A_LO, 32'd11);

        // LO->HI carry.
        wr_reg(A_HI, 32'h0);
        wr_reg(A_LO, 32'hFFFF_FFFE);
        wr_reg(A_CTRL, 32'h0000_0001);
        rd_chk("carry lo0", A_LO, 32'hFFFF_FFFE);
        rd_chk("carry lo1", A_LO, 32'hFFFF_FFFF);
        rd_chk("carry lo2", A_LO, 32'h0);
        rd_chk("carry hi", A_HI, 32'h1);
        wr_reg(A_CTRL, 32'h0);

        // 64-bit wrap sets WRAP; WRAP is write-1-to-clear only on bit1.
        wr_reg(A_HI, 32'hFFFF_FFFF);
        wr_reg(A_LO, 32'hFFFF_FFFF);
        wr_reg(A_CTRL, 32'h0000_0001);
        rd_chk("wrap pre lo", A_LO, 32'hFFFF_FFFF);
        rd_chk("wrap hi", A_HI, 32'h0);
        rd_chk("wrap status", A_STAT, 32'h2);
        wr_reg(A_CTRL, 32'h0);
        wr_reg(A_STAT, 32'h1);
        rd_chk("wrap w1 bit0", A_STAT, 32'h2);
        wr_reg(A_STAT, 32'h2);
        rd_chk("wrap cleared", A_STAT, 32'h0);

        // Interrupt with mtimecmp = 20, PRESC = 0.
        wr_reg(A_LO, 32'h0);
        wr_reg(A_HI, 32'h0);
        wr_reg(A_CHI, 32'h0);
        wr_reg(A_CLO, 32'd20);
        wr_reg(A_CTRL, 32'h0000_0003);
        idle(20);
        rd_chk("intr mtime 20", A_LO, 32'd20);
        check("intr t at 20", 32'(t_intr), 32'h0);
        tchk("intr rise", 1'b1);
        wr_reg(A_CLO, 32'd100);
        tchk("intr hold after cmp write", 1'b1);
        tchk("intr fall", 1'b0);
        wr_reg(A_CLO, 32'd10);
        tchk("intr cmp10 pre", 1'b0);
        tchk("intr cmp10 rise", 1'b1);
        wr_reg(A_CTRL, 32'h0000_0001);
        tchk("intr hold after ie write", 1'b1);
        rd_chk("intr pend no ie", A_STAT, 32'h1);
        check("intr ie cleared", 32'(t_intr), 32'h0);

        // Write/tick collisions, still ticking every cycle.
        wr_reg(A_CHI, 32'hFFFF_FFFF);
        wr_reg(A_CLO, 32'hFFFF_FFFF);
        wr_reg(A_LO, 32'hFFFF_FFFE);
        idle(1);
        wr_reg(A_HI, 32'h7);
        rd_chk("coll hi-write lo", A_LO, 32'h0);
        rd_chk("coll hi-write hi", A_HI, 32'h7);
        wr_reg(A_LO, 32'hFFFF_FFFE);
        idle(1);
        wr_reg(A_LO, 32'h55);
        rd_chk("coll lo-write lo", A_LO, 32'h55);
        rd_chk("coll lo-write hi", A_HI, 32'h7);
        wr_reg(A_CTRL, 32'h0);

        // Async reset while counting with t_intr high.
        wr_reg(A_CHI, 32'h0);
        wr_reg(A_CLO, 32'h0);
        wr_reg(A_CTRL, 32'h0000_0003);
        idle(1);
        tchk("arst pre t_intr", 1'b1);
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0; addr = BASE;
        #1 rst = 1'b0;
        #1 check("arst t_intr", 32'(t_intr), 32'h0);
        rd_en = 1'b1; addr = A_LO;
        #1 check("arst mtime lo", rdata, 32'h0);
        addr = A_CLO;
        #1 check("arst cmp lo", rdata, 32'hFFFF_FFFF);
        @(negedge clk);
        addr = A_CTRL;
        #1 check("arst ctrl", rdata, 32'h0);
        addr = A_STAT;
        #1 check("arst status", rdata, 32'h0);
        rd_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        idle(3);
        rd_chk("arst no count", A_LO, 32'h0);
        wr_reg(A_CTRL, 32'h0000_0001);
        rd_chk("arst resume 0", A_LO, 32'h0);
        rd_chk("arst resume 1", A_LO, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
